// File: rtl/control_sequencer_if.sv
// Control bundle between the sequencer and the datapath:
// instruction and stop request in, load enables and selects out.
interface control_sequencer_if;
    logic        stop;
    logic [31:0] IR_Data;
    logic        run;
    logic [4:0]  alu_instruction;
    logic        PC_enable;
    logic        PC_increment_enable;
    logic        IR_enable;
    logic        Y_enable;
    logic        Z_enable;
    logic        MAR_enable;
    logic        MDR_enable;
    logic        r_enable;
    logic        HI_enable;
    logic        PC_select;
    logic        MDR_select;
    logic        Z_LO_select;
    logic        c_select;
    logic        r_select;
    logic        HI_select;
    logic        LO_select;
    logic        read;
    logic        write;
    logic        Gra;
    logic        Grb;
    logic        Grc;
    logic        BAout;

    modport master (
        input  stop, IR_Data,
        output run, alu_instruction,
        output PC_enable, PC_increment_enable, IR_enable,
        output Y_enable, Z_enable, MAR_enable, MDR_enable,
        output r_enable, HI_enable,
        output PC_select, MDR_select, Z_LO_select, c_select,
        output r_select, HI_select, LO_select, read, write,
        output Gra, Grb, Grc, BAout
    );

    modport slave (
        output stop, IR_Data,
        input  run, alu_instruction,
        input  PC_enable, PC_increment_enable, IR_enable,
        input  Y_enable, Z_enable, MAR_enable, MDR_enable,
        input  r_enable, HI_enable,
        input  PC_select, MDR_select, Z_LO_select, c_select,
        input  r_select, HI_select, LO_select, read, write,
        input  Gra, Grb, Grc, BAout
    );
endinterface

// File: rtl/control_sequencer.sv
// Moore control sequencer: fetch T0-T2, execute T3-T7, HALT.
// Outputs decode only the state register (phase + latched class).
module control_sequencer #(
    parameter logic [4:0] ALU_ADD = 5'b00001,
    parameter logic [4:0] ALU_SUB = 5'b00010
) (
    input  logic                clk,
    input  logic                reset,
    control_sequencer_if.master bus
);

    typedef enum logic [3:0] {
        RESET, T0, T1, T2, T3, T4, T5, T6, T7, HALT
    } state_t;

    typedef enum logic [3:0] {
        I_NOP, I_LD, I_LDI, I_ST, I_ADD,
        I_SUB, I_ADDI, I_MFHI, I_MFLO
    } instr_t;

    state_t state, state_n, end_n;
    instr_t instr, dec;
    logic [4:0] op;

    assign op = bus.IR_Data[31:27];

    always_comb begin
        dec = I_NOP;
        case (op)
            5'b00000: dec = I_LD;
            5'b00001: dec = I_LDI;
            5'b00010: dec = I_ST;
            5'b00011: dec = I_ADD;
            5'b00100: dec = I_SUB;
            5'b01100: dec = I_ADDI;
            5'b11000: dec = I_MFHI;
            5'b11001: dec = I_MFLO;
            default:  dec = I_NOP;
        endcase
    end

    // The class is latched at T2 so execute outputs depend on state only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RESET;
            instr <= I_NOP;
        end else begin
            state <= state_n;
            if (state == T2)
                instr <= dec;
        end
    end

    always_comb begin
        end_n   = bus.stop ? HALT : T0;
        state_n = state;
        case (state)
            RESET: state_n = T0;
            T0:    state_n = T1;
            T1:    state_n = T2;
            T2: begin
                if (op == 5'b11011)
                    state_n = HALT;
                else if (dec == I_NOP)
                    state_n = end_n;
                else
                    state_n = T3;
            end
            T3: state_n = (instr == I_MFHI || instr == I_MFLO)
                          ? end_n : T4;
            T4: state_n = T5;
            T5: state_n = (instr == I_LD || instr == I_ST)
                          ? T6 : end_n;
            T6:      state_n = T7;
            T7:      state_n = end_n;
            HALT:    state_n = HALT;
            default: state_n = RESET;
        endcase
    end

    always_comb begin
        bus.run                 = (state != HALT);
        bus.alu_instruction     = 5'b00000;
        bus.PC_enable           = 1'b0;
        bus.PC_increment_enable = 1'b0;
        bus.IR_enable           = 1'b0;
        bus.Y_enable            = 1'b0;
        bus.Z_enable            = 1'b0;
        bus.MAR_enable          = 1'b0;
        bus.MDR_enable          = 1'b0;
        bus.r_enable            = 1'b0;
        bus.HI_enable           = 1'b0;
        bus.PC_select           = 1'b0;
        bus.MDR_select          = 1'b0;
        bus.Z_LO_select         = 1'b0;
        bus.c_select            = 1'b0;
        bus.r_select            = 1'b0;
        bus.HI_select           = 1'b0;
        bus.LO_select           = 1'b0;
        bus.read                = 1'b0;
        bus.write               = 1'b0;
        bus.Gra                 = 1'b0;
        bus.Grb                 = 1'b0;
        bus.Grc                 = 1'b0;
        bus.BAout               = 1'b0;
        case (state)
            T0: begin
                bus.PC_select  = 1'b1;
                bus.MAR_enable = 1'b1;
            end
            T1: begin
                bus.PC_increment_enable = 1'b1;
                bus.read                = 1'b1;
                bus.MDR_enable          = 1'b1;
            end
            T2: begin
                bus.MDR_select = 1'b1;
                bus.IR_enable  = 1'b1;
            end
            T3: begin
                case (instr)
                    I_LD, I_LDI, I_ST: begin
                        bus.Grb      = 1'b1;
                        bus.BAout    = 1'b1;
                        bus.Y_enable = 1'b1;
                    end
                    I_ADD, I_SUB, I_ADDI: begin
                        bus.Grb      = 1'b1;
                        bus.r_select = 1'b1;
                        bus.Y_enable = 1'b1;
                    end
                    I_MFHI: begin
                        bus.Gra       = 1'b1;
                        bus.r_enable  = 1'b1;
                        bus.HI_select = 1'b1;
                    end
                    I_MFLO: begin
                        bus.Gra       = 1'b1;
                        bus.r_enable  = 1'b1;
                        bus.LO_select = 1'b1;
                    end
                    default: ;
                endcase
            end
            T4: begin
                bus.Z_enable = 1'b1;
                case (instr)
                    I_ADD: begin
                        bus.Grc             = 1'b1;
                        bus.r_select        = 1'b1;
                        bus.alu_instruction = ALU_ADD;
                    end
                    I_SUB: begin
                        bus.Grc             = 1'b1;
                        bus.r_select        = 1'b1;
                        bus.alu_instruction = ALU_SUB;
                    end
                    default: begin
                        bus.c_select        = 1'b1;
                        bus.alu_instruction = ALU_ADD;
                    end
                endcase
            end
            T5: begin
                bus.Z_LO_select = 1'b1;
                if (instr == I_LD || instr == I_ST) begin
                    bus.MAR_enable = 1'b1;
                end else begin
                    bus.Gra      = 1'b1;
                    bus.r_enable = 1'b1;
                end
            end
            T6: begin
                bus.MDR_enable = 1'b1;
                if (instr == I_LD) begin
                    bus.read = 1'b1;
                end else begin
                    bus.Gra      = 1'b1;
                    bus.r_select = 1'b1;
                end
            end
            T7: begin
                if (instr == I_LD) begin
                    bus.MDR_select = 1'b1;
                    bus.Gra        = 1'b1;
                    bus.r_enable   = 1'b1;
                end else begin
                    bus.write = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench: per-cycle expected output words are queued by the
// stimulus and popped/compared by a negedge monitor.
module tb_control_sequencer;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    control_sequencer_if bus();

    control_sequencer #(.ALU_ADD(5'b00001), .ALU_SUB(5'b00010)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    localparam logic [27:0] RUN  = 28'd1 << 27;
    localparam logic [27:0] AADD = 28'd1 << 22;
    localparam logic [27:0] ASUB = 28'd2 << 22;
    localparam logic [27:0] PCI  = 28'd1 << 20;
    localparam logic [27:0] IRE  = 28'd1 << 19;
    localparam logic [27:0] YE   = 28'd1 << 18;
    localparam logic [27:0] ZE   = 28'd1 << 17;
    localparam logic [27:0] MARE = 28'd1 << 16;
    localparam logic [27:0] MDRE = 28'd1 << 15;
    localparam logic [27:0] RE   = 28'd1 << 14;
    localparam logic [27:0] PCS  = 28'd1 << 12;
    localparam logic [27:0] MDRS = 28'd1 << 11;
    localparam logic [27:0] ZLS  = 28'd1 << 10;
    localparam logic [27:0] CS   = 28'd1 << 9;
    localparam logic [27:0] RS   = 28'd1 << 8;
    localparam logic [27:0] HIS  = 28'd1 << 7;
    localparam logic [27:0] LOS  = 28'd1 << 6;
    localparam logic [27:0] RD   = 28'd1 << 5;
    localparam logic [27:0] WR   = 28'd1 << 4;
    localparam logic [27:0] GRA  = 28'd1 << 3;
    localparam logic [27:0] GRB  = 28'd1 << 2;
    localparam logic [27:0] GRC  = 28'd1 << 1;
    localparam logic [27:0] BAO  = 28'd1 << 0;

    localparam logic [31:0] OP_LDI  = 32'h0880_0005;
    localparam logic [31:0] OP_MFHI = 32'hC080_0000;
    localparam logic [31:0] OP_MFLO = 32'hC800_0000;
    localparam logic [31:0] OP_ST   = 32'h1080_0010;
    localparam logic [31:0] OP_LD   = 32'h0000_0000;
    localparam logic [31:0] OP_ADD  = 32'h1800_0000;
    localparam logic [31:0] OP_SUB  = 32'h2000_0000;
    localparam logic [31:0] OP_ADDI = 32'h6000_0000;
    localparam logic [31:0] OP_NOP  = 32'hD000_0000;
    localparam logic [31:0] OP_HALT = 32'hD800_0000;
    localparam logic [31:0] OP_BAD  = 32'hF800_0000;

    logic [27:0] got;
    assign got = {bus.run, bus.alu_instruction,
                  bus.PC_enable, bus.PC_increment_enable, bus.IR_enable,
                  bus.Y_enable, bus.Z_enable, bus.MAR_enable,
                  bus.MDR_enable, bus.r_enable, bus.HI_enable,
                  bus.PC_select, bus.MDR_select, bus.Z_LO_select,
                  bus.c_select, bus.r_select, bus.HI_select, bus.LO_select,
                  bus.read, bus.write,
                  bus.Gra, bus.Grb, bus.Grc, bus.BAout};

    logic [27:0] q[$];
    logic [27:0] seq[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(negedge clk) begin
        logic [27:0] e;
        int nsel;
        cyc++;
        if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL outputs cycle %0d: got %h expected %h",
                         cyc, got, e);
            end
            nsel = $countones({bus.PC_select, bus.MDR_select,
                               bus.Z_LO_select, bus.c_select, bus.r_select,
                               bus.HI_select, bus.LO_select});
            checks++;
            if (nsel > 1) begin
                errors++;
                $display("FAIL bus_select_onehot cycle %0d: got %0d selects expected <=1",
                         cyc, nsel);
            end
        end
    end

    task automatic step(input logic [27:0] exp, input logic rst_v,
                        input logic stp, input logic [31:0] ir);
        q.push_back(exp);
        reset       = rst_v;
        bus.stop    = stp;
        bus.IR_Data = ir;
        @(posedge clk);
        #1;
    endtask

    task automatic make_seq(input logic [4:0] op);
        seq.delete();
        seq.push_back(RUN | PCS | MARE);
        seq.push_back(RUN | PCI | RD | MDRE);
        seq.push_back(RUN | MDRS | IRE);
        case (op)
            5'b00001: begin
                seq.push_back(RUN | GRB | BAO | YE);
                seq.push_back(RUN | CS | AADD | ZE);
                seq.push_back(RUN | ZLS | GRA | RE);
            end
            5'b00000: begin
                seq.push_back(RUN | GRB | BAO | YE);
                seq.push_back(RUN | CS | AADD | ZE);
                seq.push_back(RUN | ZLS | MARE);
                seq.push_back(RUN | RD | MDRE);
                seq.push_back(RUN | MDRS | GRA | RE);
            end
            5'b00010: begin
                seq.push_back(RUN | GRB | BAO | YE);
                seq.push_back(RUN | CS | AADD | ZE);
                seq.push_back(RUN | ZLS | MARE);
                seq.push_back(RUN | GRA | RS | MDRE);
                seq.push_back(RUN | WR);
            end
            5'b00011, 5'b00100: begin
                seq.push_back(RUN | GRB | RS | YE);
                seq.push_back(RUN | GRC | RS | ZE |
                              ((op == 5'b00011) ? AADD : ASUB));
                seq.push_back(RUN | ZLS | GRA | RE);
            end
            5'b01100: begin
                seq.push_back(RUN | GRB | RS | YE);
                seq.push_back(RUN | CS | AADD | ZE);
                seq.push_back(RUN | ZLS | GRA | RE);
            end
            5'b11000: seq.push_back(RUN | GRA | RE | HIS);
            5'b11001: seq.push_back(RUN | GRA | RE | LOS);
            default: ;
        endcase
    endtask

    task automatic instr(input logic [31:0] ir, input int stop_idx,
                         input int rst_idx);
        make_seq(ir[31:27]);
        for (int i = 0; i < seq.size(); i++) begin
            step(seq[i], (i == rst_idx), (i == stop_idx), ir);
            if (i == rst_idx) break;
        end
    endtask

    initial begin
        reset       = 1'b1;
        bus.stop    = 1'b0;
        bus.IR_Data = 32'h0;
        @(posedge clk);
        #1;
        step(RUN, 1'b1, 1'b0, 32'h0);
        step(RUN, 1'b0, 1'b0, 32'h0);

        instr(OP_LDI, -1, -1);
        instr(OP_MFHI, -1, -1);
        instr(OP_ST, -1, -1);
        instr(OP_ADD, 4, -1);
        instr(OP_SUB, -1, -1);
        instr(OP_ADDI, -1, -1);
        instr(OP_MFLO, -1, -1);
        instr(OP_LD, -1, -1);
        instr(OP_NOP, -1, -1);

        // stop held at the final edge of add parks the machine
        instr(OP_ADD, 5, -1);
        repeat (3) step(28'd0, 1'b0, 1'b0, OP_LDI);
        step(28'd0, 1'b1, 1'b0, OP_LDI);
        step(RUN, 1'b0, 1'b0, OP_LDI);

        instr(OP_HALT, -1, -1);
        repeat (20) step(28'd0, 1'b0, 1'b1, OP_LDI);
        step(28'd0, 1'b1, 1'b0, OP_LDI);
        step(RUN, 1'b0, 1'b0, OP_LDI);

        instr(OP_LD, -1, 6);
        step(RUN, 1'b0, 1'b0, OP_BAD);
        instr(OP_BAD, -1, -1);
        instr(OP_LDI, -1, -1);

        for (int k = 0; k < 5 && q.size() > 0; k++)
            @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
